// File: rtl/icon_operand_mover.sv
`default_nettype none
// ============================================================================
// Module   : icon_operand_mover
// Purpose  : Interconnect-side mover that fetches foreign operands from a
//            producing EU's cache TX read port and writes them into the
//            consuming EU's cache RX write channel. Requests are queued in a
//            small FIFO; a head request that keeps missing is rotated to the
//            tail so an unproduced operand cannot block the others.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W      - operand address width
//   DATA_W      - operand data width
//   REQ_DEPTH   - request FIFO entries (power of 2, >= 2)
//   RETRY_LIMIT - consecutive head misses before rotation (>= 1)
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   req_addr/req_valid/req_ready      - fetch request input (ready = ~full)
//   src_r_addr/src_r_ready            - producer read address / strobe (out)
//   src_r_data/src_r_valid            - producer read data / hit (in)
//   dst_w_addr/dst_w_data/dst_w_valid - consumer write channel (out)
//   dst_w_ready                       - consumer ready (in)
//   busy                              - FIFO non-empty or FSM active
// Optional (macro ICON_MOVER_STATS_EN):
//   stat_moves, stat_rotates, stat_stall - 16-bit saturating counters
// ============================================================================
module icon_operand_mover #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int REQ_DEPTH   = 4,
  parameter int RETRY_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [ADDR_W-1:0] src_r_addr,
  output logic              src_r_ready,
  input  logic [DATA_W-1:0] src_r_data,
  input  logic              src_r_valid,
  output logic [ADDR_W-1:0] dst_w_addr,
  output logic [DATA_W-1:0] dst_w_data,
  output logic              dst_w_valid,
  input  logic              dst_w_ready,
  output logic              busy
`ifdef ICON_MOVER_STATS_EN
  ,
  output logic [15:0]       stat_moves,
  output logic [15:0]       stat_rotates,
  output logic [15:0]       stat_stall
`endif
);

  localparam int c_PTR_W = $clog2(REQ_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_RTY_W = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_mem [REQ_DEPTH];
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_RTY_W-1:0]  r_retry;
  logic [ADDR_W-1:0]   r_src_addr;
  logic [ADDR_W-1:0]   r_dst_addr;
  logic [DATA_W-1:0]   r_dst_data;

  logic [ADDR_W-1:0]   w_head;
  logic [ADDR_W-1:0]   w_next_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ext;
  logic                w_in_rd;
  logic                w_hit;
  logic                w_miss;
  logic                w_rotate;
  logic                w_pop;
  logic                w_load_src;
  logic [c_PTR_W-1:0]  w_ext_slot;
  logic [c_CNT_W:0]    w_count_sum;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_full     = (r_count == c_CNT_W'(REQ_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_ext = req_valid & ~w_full;
  assign w_in_rd    = (r_state == ST_RD);
  assign w_hit      = w_in_rd & src_r_valid;
  assign w_miss     = w_in_rd & ~src_r_valid;
  assign w_rotate   = w_miss & (r_retry == c_RTY_W'(RETRY_LIMIT - 1));
  assign w_pop      = w_hit | w_rotate;
  // The rotated entry takes the tail slot first; a coincident request lands after it.
  assign w_ext_slot = r_wr_ptr + c_PTR_W'(w_rotate);

  // Head after this cycle's update. Only a rotation needs the look-ahead: with a
  // single entry the rotated address is still being written, so forward it.
  always_comb begin
    w_next_head = w_head;
    if (w_rotate) begin
      if (r_count == c_CNT_W'(1)) begin
        w_next_head = w_head;
      end else begin
        w_next_head = r_mem[r_rd_ptr + c_PTR_W'(1)];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_src  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_RD;
          w_load_src  = 1'b1;
        end
      end
      ST_RD: begin
        if (w_hit) begin
          w_state_nxt = ST_WR;
        end else if (w_rotate) begin
          w_load_src  = 1'b1;
        end
      end
      ST_WR: begin
        if (dst_w_ready) begin
          if (!w_empty) begin
            w_state_nxt = ST_RD;
            w_load_src  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_retry    <= '0;
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_dst_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_rotate) + c_PTR_W'(w_push_ext);
      // A rotation pops and pushes, leaving occupancy unchanged.
      r_count  <= r_count + c_CNT_W'(w_push_ext) + c_CNT_W'(w_rotate) - c_CNT_W'(w_pop);
      if (w_hit || w_rotate) begin
        r_retry <= '0;
      end else if (w_miss) begin
        r_retry <= r_retry + c_RTY_W'(1);
      end
      if (w_load_src) begin
        r_src_addr <= w_next_head;
      end
      if (w_hit) begin
        r_dst_addr <= w_head;
        r_dst_data <= src_r_data;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_rotate) begin
      r_mem[r_wr_ptr] <= w_head;
    end
    if (w_push_ext) begin
      r_mem[w_ext_slot] <= req_addr;
    end
  end

  assign w_count_sum = {1'b0, r_count} + (c_CNT_W + 1)'(w_push_ext) + (c_CNT_W + 1)'(w_rotate);

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    (w_count_sum - (c_CNT_W + 1)'(w_pop)) <= (c_CNT_W + 1)'(REQ_DEPTH));

  assign req_ready   = ~w_full;
  assign src_r_addr  = r_src_addr;
  assign src_r_ready = (r_state == ST_RD);
  assign dst_w_addr  = r_dst_addr;
  assign dst_w_data  = r_dst_data;
  assign dst_w_valid = (r_state == ST_WR);
  assign busy        = ~w_empty | (r_state != ST_IDLE);

`ifdef ICON_MOVER_STATS_EN
  logic [15:0] r_stat_moves;
  logic [15:0] r_stat_rotates;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_moves   <= '0;
      r_stat_rotates <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (dst_w_valid && dst_w_ready && (r_stat_moves != 16'hFFFF)) begin
        r_stat_moves <= r_stat_moves + 16'd1;
      end
      if (w_rotate && (r_stat_rotates != 16'hFFFF)) begin
        r_stat_rotates <= r_stat_rotates + 16'd1;
      end
      if (dst_w_valid && !dst_w_ready && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_moves   = r_stat_moves;
  assign stat_rotates = r_stat_rotates;
  assign stat_stall   = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icon_operand_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_icon_operand_mover
// Purpose  : Self-checking bench for icon_operand_mover. Table-driven single
//            moves, hand-written multi-cycle sequences and a randomized phase
//            scored against a multiset-of-pending-requests reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icon_operand_mover;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int RL    = 8;

  localparam int M_ALWAYS = 0;
  localparam int M_NEVER  = 1;
  localparam int M_MISS   = 2;
  localparam int M_RANDOM = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] req_addr;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] src_r_addr;
  logic          src_r_ready;
  logic [DW-1:0] src_r_data;
  logic          src_r_valid;
  logic [AW-1:0] dst_w_addr;
  logic [DW-1:0] dst_w_data;
  logic          dst_w_valid;
  logic          dst_w_ready;
  logic          busy;
`ifdef ICON_MOVER_STATS_EN
  logic [15:0]   stat_moves;
  logic [15:0]   stat_rotates;
  logic [15:0]   stat_stall;
`endif

  always #5 clk = ~clk;

  icon_operand_mover #(
    .ADDR_W(AW), .DATA_W(DW), .REQ_DEPTH(DEPTH), .RETRY_LIMIT(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .src_r_addr(src_r_addr), .src_r_ready(src_r_ready),
    .src_r_data(src_r_data), .src_r_valid(src_r_valid),
    .dst_w_addr(dst_w_addr), .dst_w_data(dst_w_data),
    .dst_w_valid(dst_w_valid), .dst_w_ready(dst_w_ready),
    .busy(busy)
`ifdef ICON_MOVER_STATS_EN
    ,
    .stat_moves(stat_moves), .stat_rotates(stat_rotates), .stat_stall(stat_stall)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            accepted = 0;
  wr_t           wlog[$];
  logic [AW-1:0] polls[$];
  logic [AW-1:0] pend[$];
  int            prod_mode = M_ALWAYS;
  logic [AW-1:0] miss_addr = '0;
  bit            fixed_en = 1'b0;
  logic [DW-1:0] fixed_data = '0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return {a ^ 16'hA5C3, a + 16'h1234};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes the cycle just before the active edge: acceptance, delivery, protocol.
  task automatic monitor();
    int idx;
    if (!reset_n) return;
    if (src_r_ready) polls.push_back(src_r_addr);
    chk("rd_wr_exclusive", src_r_ready & dst_w_valid, 0);
    if (prev_stall) begin
      chk("stall_hold_valid", dst_w_valid, 1);
      chk("stall_hold_addr", dst_w_addr, prev_addr);
      chk("stall_hold_data", dst_w_data, prev_data);
    end
    prev_stall = dst_w_valid && !dst_w_ready;
    prev_addr  = dst_w_addr;
    prev_data  = dst_w_data;
    if (req_valid && req_ready) begin
      accepted++;
      pend.push_back(req_addr);
    end
    if (dst_w_valid && dst_w_ready) begin
      wlog.push_back('{dst_w_addr, dst_w_data, cyc});
      idx = -1;
      for (int i = 0; i < pend.size(); i++) begin
        if (idx < 0 && pend[i] == dst_w_addr) idx = i;
      end
      chk("wr_addr_was_requested", idx >= 0, 1);
      if (idx >= 0) begin
        pend.delete(idx);
        chk("wr_data", dst_w_data, fixed_en ? fixed_data : f(dst_w_addr));
      end
    end
  endtask

  task automatic drive_prod();
    bit v;
    src_r_data = fixed_en ? fixed_data : f(src_r_addr);
    case (prod_mode)
      M_ALWAYS: v = 1'b1;
      M_NEVER:  v = 1'b0;
      M_MISS:   v = (src_r_addr != miss_addr);
      default:  v = ($urandom_range(0, 2) == 0);
    endcase
    src_r_valid = src_r_ready && v;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    drive_prod();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic async_reset_pulse();
    reset_n = 1'b0;
    pend.delete();
    prev_stall = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_prod();
  endtask

  vec_t vecs[5];

  initial begin
    int base;
    int n;
    int n4;
    int acc0;
    logic [3:0] mask;
`ifdef ICON_MOVER_STATS_EN
    logic [15:0] s0;
    logic [15:0] r0;
`endif

    vecs[0] = '{16'h0005, 32'h0000ABCD, 0, 16'h0005, 32'h0000ABCD};
    vecs[1] = '{16'h0000, 32'h00000001, 0, 16'h0000, 32'h00000001};
    vecs[2] = '{16'hFFFF, 32'hFFFFFFFF, 2, 16'hFFFF, 32'hFFFFFFFF};
    vecs[3] = '{16'h1234, 32'hDEADBEEF, 5, 16'h1234, 32'hDEADBEEF};
    vecs[4] = '{16'h8000, 32'h00000001, 1, 16'h8000, 32'h00000001};

    reset_n     = 1'b0;
    req_addr    = '0;
    req_valid   = 1'b0;
    dst_w_ready = 1'b0;
    src_r_valid = 1'b0;
    src_r_data  = '0;
    #3;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_src_r_ready", src_r_ready, 0);
    chk("reset_dst_w_valid", dst_w_valid, 0);
    chk("reset_src_r_addr", src_r_addr, 0);
    chk("reset_dst_w_addr", dst_w_addr, 0);
    chk("reset_dst_w_data", dst_w_data, 0);
    release_reset();
    tick();

    // ---- table-driven single moves (incl. consumer backpressure) ----
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      fixed_en   = 1'b1;
      fixed_data = vecs[v].data;
      prod_mode  = M_ALWAYS;
      base       = wlog.size();
`ifdef ICON_MOVER_STATS_EN
      s0 = stat_stall;
`endif
      req_addr    = vecs[v].addr;
      req_valid   = 1'b1;
      dst_w_ready = (vecs[v].stall == 0);
      tick();
      req_valid = 1'b0;
      tick();
      chk("mv_rd_ready", src_r_ready, 1);
      chk("mv_rd_addr", src_r_addr, vecs[v].exp_addr);
      chk("mv_no_early_wr", dst_w_valid, 0);
      tick();
      chk("mv_wr_valid_at_2", dst_w_valid, 1);
      chk("mv_wr_addr", dst_w_addr, vecs[v].exp_addr);
      chk("mv_wr_data", dst_w_data, vecs[v].exp_data);
      chk("mv_wr_no_rd", src_r_ready, 0);
      for (int s = 0; s < vecs[v].stall; s++) begin
        tick();
        chk("mv_stall_no_rd", src_r_ready, 0);
      end
      dst_w_ready = 1'b1;
      tick();
      chk("mv_done_valid", dst_w_valid, 0);
      chk("mv_done_busy", busy, 0);
      chk("mv_one_write", wlog.size() - base, 1);
`ifdef ICON_MOVER_STATS_EN
      chk("mv_stat_stall", stat_stall - s0, vecs[v].stall);
`endif
    end
    fixed_en = 1'b0;

    // ---- back-to-back ----
    wait_idle();
    prod_mode   = M_ALWAYS;
    dst_w_ready = 1'b1;
    base        = wlog.size();
    for (int i = 1; i <= 3; i++) begin
      req_addr  = AW'(i);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    n = 0;
    while (wlog.size() - base < 3 && n < 30) begin
      tick();
      n++;
    end
    chk("b2b_count", wlog.size() - base, 3);
    if (wlog.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_order", wlog[base + i].addr, i + 1);
      chk("b2b_gap_1", wlog[base + 1].cyc - wlog[base].cyc, 2);
      chk("b2b_gap_2", wlog[base + 2].cyc - wlog[base + 1].cyc, 2);
    end

    // ---- rotation ----
    wait_idle();
    prod_mode = M_MISS;
    miss_addr = 16'h0004;
    base      = wlog.size();
    polls.delete();
    req_valid = 1'b1;
    req_addr  = 16'h0004;
    tick();
    req_addr  = 16'h0006;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (wlog.size() - base < 1 && n < 40) begin
      tick();
      n++;
    end
    tick();
    tick();
    n4 = 0;
    while (n4 < polls.size() && polls[n4] == 16'h0004) n4++;
    chk("rot_polls_on_4", n4, RL);
    chk("rot_poll_count", polls.size() >= RL + 2, 1);
    if (polls.size() >= RL + 2) begin
      chk("rot_then_6", polls[RL], 16'h0006);
      chk("rot_repoll_4", polls[RL + 1], 16'h0004);
    end
    chk("rot_first_delivery_count", wlog.size() - base, 1);
    if (wlog.size() - base >= 1) chk("rot_first_is_6", wlog[base].addr, 16'h0006);
    prod_mode = M_ALWAYS;
    n = 0;
    while (wlog.size() - base < 2 && n < 40) begin
      tick();
      n++;
    end
    chk("rot_second_count", wlog.size() - base, 2);
    if (wlog.size() - base >= 2) begin
      chk("rot_second_is_4", wlog[base + 1].addr, 16'h0004);
      chk("rot_second_data", wlog[base + 1].data, f(16'h0004));
    end

    // ---- full FIFO with rotations ----
    wait_idle();
    prod_mode = M_NEVER;
    base      = wlog.size();
    acc0      = accepted;
`ifdef ICON_MOVER_STATS_EN
    r0 = stat_rotates;
`endif
    for (int i = 0; i < 6; i++) begin
      req_addr  = AW'(16'h0010 + i);
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    chk("full_accepted", accepted - acc0, DEPTH);
    chk("full_req_ready", req_ready, 0);
    repeat (40) tick();
    chk("full_ready_during_rot", req_ready, 0);
    chk("full_no_writes", wlog.size() - base, 0);
    chk("full_busy", busy, 1);
`ifdef ICON_MOVER_STATS_EN
    chk("full_stat_rotates", (stat_rotates - r0) > 0, 1);
`endif
    prod_mode   = M_ALWAYS;
    dst_w_ready = 1'b1;
    n = 0;
    while (wlog.size() - base < DEPTH && n < 60) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("full_deliveries", wlog.size() - base, DEPTH);
    mask = '0;
    for (int i = base; i < wlog.size(); i++) begin
      if (wlog[i].addr >= 16'h0010 && wlog[i].addr <= 16'h0013) mask[wlog[i].addr[1:0]] = 1'b1;
    end
    chk("full_all_delivered", mask, 4'hF);

    // ---- async reset during RD ----
    wait_idle();
    prod_mode = M_NEVER;
    req_addr  = 16'h0020;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rstrd_in_rd", src_r_ready, 1);
    async_reset_pulse();
    chk("rstrd_src_ready", src_r_ready, 0);
    chk("rstrd_busy", busy, 0);
    chk("rstrd_req_ready", req_ready, 1);
    chk("rstrd_src_addr", src_r_addr, 0);
    release_reset();
    prod_mode = M_ALWAYS;
    base = wlog.size();
    repeat (10) tick();
    chk("rstrd_no_write", wlog.size() - base, 0);
    chk("rstrd_idle", busy, 0);

    // ---- async reset during WR ----
    dst_w_ready = 1'b0;
    req_valid   = 1'b1;
    req_addr    = 16'h0021;
    tick();
    req_addr    = 16'h0022;
    tick();
    req_valid   = 1'b0;
    tick();
    chk("rstwr_in_wr", dst_w_valid, 1);
    async_reset_pulse();
    chk("rstwr_dst_valid", dst_w_valid, 0);
    chk("rstwr_src_ready", src_r_ready, 0);
    chk("rstwr_dst_addr", dst_w_addr, 0);
    chk("rstwr_dst_data", dst_w_data, 0);
    chk("rstwr_busy", busy, 0);
    release_reset();
    dst_w_ready = 1'b1;
    base = wlog.size();
    repeat (10) tick();
    chk("rstwr_no_write", wlog.size() - base, 0);

    // ---- randomized traffic against the pending-multiset model ----
    prod_mode = M_RANDOM;
    base      = wlog.size();
    acc0      = accepted;
    for (int i = 0; i < 400; i++) begin
      req_valid   = ($urandom_range(0, 1) == 1);
      req_addr    = AW'($urandom);
      dst_w_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid   = 1'b0;
    prod_mode   = M_ALWAYS;
    dst_w_ready = 1'b1;
    n = 0;
    while ((pend.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    chk("rnd_all_drained", pend.size(), 0);
    chk("rnd_write_count", wlog.size() - base, accepted - acc0);
    chk("rnd_some_traffic", (accepted - acc0) > 20, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icon_operand_mover.md
Name: icon_operand_mover

Overview:
- Interconnect-side mover that transfers foreign operands between execution units.
- Accepts fetch requests (operand addresses) from the issue side and polls the producing EU's cache TX read port (addr/ready out, data/valid in).
- Delivers each hit into the consuming EU's cache RX write channel (addr/data/valid out, ready in).
- Buffers requests in a small FIFO and rotates requests that keep missing, so one unproduced operand cannot block the rest.

Parameters:
- REQ_DEPTH, 4, request FIFO entries; power of 2, at least 2.
- RETRY_LIMIT, 8, consecutive miss cycles on the head request before it is rotated to the FIFO tail; at least 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_addr  in  $bits(type_exec_unit_addr)  operand address to fetch
- req_valid  in  1  request valid
- req_ready  out  1  FIFO can accept; equals ~full
- src_r_addr  out  $bits(type_exec_unit_addr)  address presented to the producer TX read port
- src_r_ready  out  1  read strobe to the producer
- src_r_data  in  $bits(type_exec_unit_data)  producer read data
- src_r_valid  in  1  producer hit, same cycle as src_r_ready
- dst_w_addr  out  $bits(type_exec_unit_addr)  consumer RX write address
- dst_w_data  out  $bits(type_exec_unit_data)  consumer RX write data
- dst_w_valid  out  1  write valid
- dst_w_ready  in  1  consumer RX buffer ready
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset: FIFO emptied, FSM=IDLE, retry counter=0. Outputs: src_r_ready=0, dst_w_valid=0, busy=0, req_ready=1, src_r_addr/dst_w_addr/dst_w_data = 0.
- Reset mid-operation discards queued and in-flight operands with no partial write.
- Enqueue: occurs when req_valid & req_ready. req_ready depends only on occupancy, so it stays 0 when full even during a rotation cycle. Duplicate addresses are accepted without deduplication.
- FSM state IDLE:
  - If the FIFO is non-empty, go to RD next cycle, loading src_r_addr with the head address.
  - An enqueue into an empty FIFO reaches RD one cycle after the enqueue.
- FSM state RD:
  - src_r_ready=1 and src_r_addr=head, both registered.
  - Hit (src_r_valid=1 in any RD cycle): capture src_r_data and head address into dst_w_data/dst_w_addr, pop the head, reset the retry counter, go to WR.
  - Miss: increment the retry counter. When it reaches RETRY_LIMIT, rotate in the same cycle (pop head and push the same address to the tail, occupancy unchanged), reset the counter, and stay in RD with the new head next cycle.
  - With a single entry, rotation re-presents the same address.
  - If an external enqueue coincides with a rotation, the rotated entry is written first and the new request after it. Both fit because req_ready=~full.
- FSM state WR:
  - dst_w_valid=1; addr and data held stable until dst_w_ready.
  - On handshake: go to RD if the FIFO is non-empty (back-to-back), else IDLE.
  - src_r_ready=0 throughout WR.
- Throughput: at most one operand per 2 cycles (RD hit cycle, WR accept cycle).
- The FIFO uses a wrap-around pointer pair plus a count; no overflow or underflow is possible by construction. An assertion flags a push when full.
- The retry counter is wide enough for RETRY_LIMIT and never wraps.

Optional Feature:
- Macro: ICON_MOVER_STATS_EN.
- When defined, the block adds these outputs:
  - stat_moves (16 b): completed WR handshakes.
  - stat_rotates (16 b): rotation events.
  - stat_stall (16 b): WR cycles with dst_w_ready=0.
- All counters saturate at 16'hFFFF and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic move: enqueue addr 0x5; producer hits at the first RD cycle with data 0xABCD; dst_w_ready=1. Expect dst_w_valid with addr 0x5 and data 0xABCD exactly 2 cycles after the enqueue; busy returns to 0 the next cycle.
- Back-to-back: enqueue 0x1, 0x2, 0x3; always hit; dst_w_ready=1. Expect writes in order 1, 2, 3 on every second cycle.
- Rotation: RETRY_LIMIT=8; enqueue 0x4 then 0x6; 0x4 always misses and 0x6 hits. Expect 8 RD cycles on 0x4, then 0x6 delivered, then 0x4 re-polled. Make 0x4 hit later and expect it delivered second.
- Full FIFO: REQ_DEPTH=4; hold src_r_valid=0 and push 6 requests. Expect req_ready=0 after 4 accepted, with no loss across rotations; after release, exactly 4 deliveries.
- Consumer backpressure: dst_w_ready=0 for 5 cycles during WR. Expect dst_w_addr/dst_w_data stable, src_r_ready=0, exactly one write on release; with STATS_EN, stat_stall=5.
- Async reset: assert reset_n=0 mid-RD and mid-WR. Expect dst_w_valid and src_r_ready to drop immediately and the FIFO empty; no write occurs after reset release.
